// File: rtl/demux_16_reg.sv
// Registered 1-to-16 demultiplexer: one input word is routed to a selected channel
// (or to all channels on broadcast), each channel holding a valid/ready output register.
module demux_16_reg #(
  parameter int bus = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [bus-1:0]    data_in,
  input  logic [3:0]        selector,
  input  logic              broadcast,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [16*bus-1:0] out_data,
  output logic [15:0]       out_valid,
  input  logic [15:0]       out_ready,
  output logic [7:0]        accept_count
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } ch_state_e;

  logic [15:0] ok;
  logic [15:0] load;
  logic        accept;
  logic [7:0]  count_q;
  logic [7:0]  count_d;

  // A broadcast only proceeds when every channel can take the word, so no partial writes.
  assign in_ready     = broadcast ? (&ok) : ok[selector];
  assign accept       = in_valid & in_ready;
  assign count_d      = count_q + {7'd0, accept};
  assign accept_count = count_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= 8'd0;
    end else begin
      count_q <= count_d;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_ch
      ch_state_e      state_q;
      ch_state_e      state_d;
      logic [bus-1:0] data_q;
      logic [bus-1:0] data_d;

      assign ok[gi]   = (state_q == EMPTY) | out_ready[gi];
      assign load[gi] = accept & (broadcast | (selector == 4'(gi)));

      // A reload wins over a drain, keeping the channel FULL at one word per clock.
      always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (load[gi]) begin
          state_d = FULL;
          data_d  = data_in;
        end else if ((state_q == FULL) && out_ready[gi]) begin
          state_d = EMPTY;
        end
      end

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          state_q <= EMPTY;
          data_q  <= '0;
        end else begin
          state_q <= state_d;
          data_q  <= data_d;
        end
      end

      assign out_valid[gi]            = (state_q == FULL);
      assign out_data[gi*bus +: bus]  = data_q;
    end
  endgenerate

endmodule

// File: tb/tb_demux_16_reg.sv
// Directed bench for demux_16_reg: the driver pushes expected words per channel,
// a monitor pops and compares whenever a channel hands off a word.
module tb_demux_16_reg;
  localparam int BUS = 4;

  logic              clk;
  logic              rst_n;
  logic [BUS-1:0]    data_in;
  logic [3:0]        selector;
  logic              broadcast;
  logic              in_valid;
  logic              in_ready;
  logic [16*BUS-1:0] out_data;
  logic [15:0]       out_valid;
  logic [15:0]       out_ready;
  logic [7:0]        accept_count;

  demux_16_reg #(.bus(BUS)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .data_in(data_in),
    .selector(selector),
    .broadcast(broadcast),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .accept_count(accept_count)
  );

  int checks = 0;
  int errors = 0;
  logic [3:0] exp_q [16][$];
  logic [7:0] exp_count = 8'd0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [BUS-1:0] ch(input int k);
    return out_data[k*BUS +: BUS];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one word for one clock; exp_rdy is the hand-derived in_ready for it.
  task automatic drive(input logic [3:0] sel, input logic [3:0] d, input logic bc,
                       input logic exp_rdy);
    selector  = sel;
    data_in   = d;
    broadcast = bc;
    in_valid  = 1'b1;
    @(negedge clk);
    chk("in_ready", {63'd0, in_ready}, {63'd0, exp_rdy});
    if (exp_rdy) begin
      exp_count = exp_count + 8'd1;
      for (int k = 0; k < 16; k++)
        if (bc || (sel == 4'(k))) exp_q[k].push_back(d);
    end
    $display("xfer sel=%0d data=%h bc=%0b ready=%0b count_exp=%0d", sel, d, bc, in_ready,
             exp_count);
    step();
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) step();
  endtask

  // Monitor: every channel handshake must match the oldest word queued for that channel.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        for (int k = 0; k < 16; k++) begin
          if (out_valid[k] && out_ready[k]) begin
            checks++;
            if (exp_q[k].size() == 0) begin
              errors++;
              $display("FAIL spurious_ch%0d actual=%h required=none", k, ch(k));
            end else begin
              logic [3:0] e;
              e = exp_q[k].pop_front();
              if (ch(k) !== e) begin
                errors++;
                $display("FAIL out_ch%0d actual=%h required=%h", k, ch(k), e);
              end
            end
          end
        end
      end
    end
  end

  initial begin
    int pending;
    rst_n     = 1'b0;
    in_valid  = 1'b1;
    selector  = 4'd3;
    data_in   = 4'hF;
    broadcast = 1'b0;
    out_ready = 16'hFFFF;
    repeat (2) step();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    chk("reset_valid", {48'd0, out_valid}, 64'h0);
    chk("reset_data", out_data, 64'h0);
    chk("reset_count", {56'd0, accept_count}, 64'h0);

    // Sweep: each word appears as a one-cycle pulse on its own channel.
    for (int i = 0; i < 16; i++) begin
      drive(4'(i), 4'(i), 1'b0, 1'b1);
      chk("sweep_valid", {48'd0, out_valid}, 64'd1 << i);
      chk("sweep_data", {60'd0, ch(i)}, 64'(i));
    end
    idle(1);
    chk("sweep_count", {56'd0, accept_count}, 64'd16);

    // Backpressure on channel 5.
    out_ready = 16'hFFDF;
    drive(4'd5, 4'hA, 1'b0, 1'b1);
    chk("bp_load", {60'd0, ch(5)}, 64'hA);
    drive(4'd5, 4'h3, 1'b0, 1'b0);
    chk("bp_hold", {60'd0, ch(5)}, 64'hA);
    chk("bp_valid_held", {63'd0, out_valid[5]}, 64'd1);
    chk("bp_count", {56'd0, accept_count}, 64'd17);
    out_ready = 16'hFFFF;
    drive(4'd5, 4'h3, 1'b0, 1'b1);
    chk("bp_reload", {60'd0, ch(5)}, 64'h3);
    chk("bp_valid_reload", {63'd0, out_valid[5]}, 64'd1);
    idle(1);

    // Drain and reload in the same cycle on channel 2.
    drive(4'd2, 4'h1, 1'b0, 1'b1);
    drive(4'd2, 4'h7, 1'b0, 1'b1);
    chk("dr_data", {60'd0, ch(2)}, 64'h7);
    chk("dr_valid", {48'd0, out_valid}, 64'h0004);
    idle(1);

    // Broadcast, then a blocked broadcast.
    drive(4'd0, 4'hC, 1'b1, 1'b1);
    chk("bc_valid", {48'd0, out_valid}, 64'hFFFF);
    chk("bc_data", out_data, 64'hCCCC_CCCC_CCCC_CCCC);
    chk("bc_count", {56'd0, accept_count}, 64'd21);
    out_ready = 16'hFDFF;
    drive(4'd0, 4'h5, 1'b1, 1'b0);
    chk("bcs_valid", {48'd0, out_valid}, 64'h0200);
    chk("bcs_data", out_data, 64'hCCCC_CCCC_CCCC_CCCC);
    drive(4'd0, 4'h5, 1'b1, 1'b0);
    chk("bcs_ch0", {60'd0, ch(0)}, 64'hC);
    chk("bcs_count", {56'd0, accept_count}, 64'd21);
    out_ready = 16'hFFFF;
    idle(2);

    // Reset in the middle of held data.
    out_ready = 16'h0000;
    for (int i = 0; i < 4; i++) drive(4'(i), 4'(i + 1), 1'b0, 1'b1);
    chk("mid_valid_pre", {48'd0, out_valid}, 64'h000F);
    in_valid = 1'b0;
    rst_n    = 1'b0;
    for (int k = 0; k < 16; k++) exp_q[k].delete();
    exp_count = 8'd0;
    step();
    rst_n = 1'b1;
    chk("mid_valid", {48'd0, out_valid}, 64'h0);
    chk("mid_data", out_data, 64'h0);
    chk("mid_count", {56'd0, accept_count}, 64'h0);
    out_ready = 16'hFFFF;

    // Counter wrap.
    for (int i = 0; i < 255; i++) drive(4'(i % 16), 4'(i % 16), 1'b0, 1'b1);
    chk("wrap_ff", {56'd0, accept_count}, 64'hFF);
    drive(4'd7, 4'h9, 1'b0, 1'b1);
    chk("wrap_zero", {56'd0, accept_count}, 64'h0);
    idle(3);

    pending = 0;
    for (int k = 0; k < 16; k++) pending += exp_q[k].size();
    chk("undelivered", 64'(pending), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/demux_16_reg.md
Name: demux_16_reg

Overview:
- Registered 1-to-16 demultiplexer, the distributing counterpart of the 16:1 selector mux.
- Routes one bus-wide input word to one of 16 destination channels, or to all 16 channels in broadcast mode.
- Each channel holds one output register, with a valid/ready handshake on the input side and on each channel.
- Sits between the datapath result bus and per-destination consumers (register lanes, output ports).

Parameters:
- bus, 4, data width of the input word and of each channel.

Ports:
- clk, input, 1, system clock; all state updates on the rising edge.
- rst_n, input, 1, reset; synchronous, active-low.
- data_in, input, bus, word to distribute.
- selector, input, 4, destination channel index 0..15.
- broadcast, input, 1, 1 = write all 16 channels; selector is ignored.
- in_valid, input, 1, data_in, selector and broadcast are valid this cycle.
- in_ready, output, 1, block accepts the input word this cycle.
- out_data, output, 16*bus, channel k occupies bits [k*bus +: bus].
- out_valid, output, 16, per-channel valid flag.
- out_ready, input, 16, per-channel consumer ready.
- accept_count, output, 8, number of input transfers accepted, wrapping.

Behaviour:
- Reset: when rst_n=0 at a clk edge, clear all 16 channel registers to 0, out_valid=0 and accept_count=0. Reset overrides every other event in that cycle. Asserting reset mid-transfer discards all held data.
- Per-channel state is two states: EMPTY (out_valid[k]=0) and FULL (out_valid[k]=1).
- Channel k can load when ok[k] = !out_valid[k] | out_ready[k].
- in_ready is combinational and has no dependency on in_valid:
  - broadcast=0: in_ready = ok[selector].
  - broadcast=1: in_ready = AND of ok[0..15].
- Accept when in_valid & in_ready.
- Load set L:
  - broadcast=0: L = {selector}.
  - broadcast=1: L = all 16 channels.
- On accept, for every k in L: the channel register takes data_in, out_valid[k]=1, and accept_count increments by 1 (mod 256) once per transfer, including a broadcast.
- Drain: for every channel k with out_valid[k] & out_ready[k] that is not reloaded this cycle, out_valid[k] goes to 0. The data register keeps its last value.
- Simultaneous drain and reload on the same channel: the channel stays FULL with the new data. This gives full throughput of 1 word per clock per channel.
- Latency: a word accepted at edge N appears on out_data/out_valid immediately after edge N (1 cycle).
- Channels not in L are untouched, except by their own drain.
- Backpressure: if the selected channel is FULL and its out_ready=0, in_ready=0. Nothing changes, and upstream must hold its inputs stable.
- Broadcast with any channel blocked: the whole word stalls. There are no partial broadcast writes.
- in_valid=0: no load and no count change; drains still proceed.
- Outputs are purely registered, except in_ready.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1 -> out_valid=16'h0000, out_data all 0, accept_count=0 after release.
- Sweep: bus=4, out_ready=16'hFFFF, present selector=i, data_in=i for i=0..15 on consecutive cycles -> each cycle in_ready=1, and one cycle later out_valid has only bit i set (pulse) with channel i=i; accept_count=16.
- Backpressure: out_ready[5]=0; send 4'hA to ch5, then 4'h3 to ch5 -> the second word sees in_ready=0 and stalls, ch5 holds 4'hA; raise out_ready[5] -> 4'h3 loads the next cycle, and out_valid[5] stays 1 throughout.
- Simultaneous drain/reload: ch2 FULL with 4'h1, out_ready[2]=1, send 4'h7 to ch2 -> the next cycle has ch2=4'h7, out_valid[2]=1, with no bubble.
- Broadcast: out_ready=16'hFFFF, broadcast=1, data_in=4'hC -> all 16 channels read 4'hC, out_valid=16'hFFFF, accept_count += 1. Then set out_ready[9]=0, hold valid, broadcast 4'h5 -> in_ready=0 and no channel changes, including channel 0.
- Reset mid-operation, plus wrap: load channels 0..3, assert rst_n=0 for 1 cycle -> all cleared. Separately, perform 256 accepts -> accept_count wraps to 0.
